// File: rtl/conversor_binario_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding and digit geometry.
package conversor_binario_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } estado_t;

  localparam int unsigned ANCHO_DIGITO = 4;
  localparam int unsigned NUM_DIGITOS  = 4;
  localparam int unsigned ANCHO_BCD    = ANCHO_DIGITO * NUM_DIGITOS;
  localparam logic [ANCHO_DIGITO-1:0] UMBRAL_SUMA3 = 4'd5;

endpackage

// File: rtl/conversor_binario_bcd_if.sv
// Start/operand handshake and BCD result bus of the converter.
interface conversor_binario_bcd_if #(
  parameter int unsigned ANCHO = 10
);
  import conversor_binario_bcd_pkg::*;

  logic                    inicio;
  logic [ANCHO-1:0]        dato;
  logic                    ocupado;
  logic                    listo;
  logic [ANCHO_DIGITO-1:0] unidades;
  logic [ANCHO_DIGITO-1:0] decenas;
  logic [ANCHO_DIGITO-1:0] centenas;
  logic [ANCHO_DIGITO-1:0] millares;

  modport master (
    output inicio, dato,
    input  ocupado, listo, unidades, decenas, centenas, millares
  );

  modport slave (
    input  inicio, dato,
    output ocupado, listo, unidades, decenas, centenas, millares
  );

endinterface

// File: rtl/conversor_binario_bcd_ajuste_suma3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module ajuste_suma3
  import conversor_binario_bcd_pkg::*;
(
  input  logic [ANCHO_DIGITO-1:0] digito,
  output logic [ANCHO_DIGITO-1:0] ajustado
);

  always_comb begin
    ajustado = digito;
    if (digito >= UMBRAL_SUMA3) ajustado = digito + 4'd3;
  end

endmodule

// File: rtl/conversor_binario_bcd.sv
// Sequential double-dabble converter: one bit per CONV cycle, result latched on entry to FIN.
module conversor_binario_bcd
  import conversor_binario_bcd_pkg::*;
#(
  parameter int unsigned ANCHO = 10
) (
  input logic              clk,
  input logic              reset,
  conversor_binario_bcd_if.slave bus
);

  localparam logic [3:0] ULTIMA = 4'(ANCHO - 1);

  estado_t              estado, estado_sig;
  logic [ANCHO-1:0]     binario, binario_sig;
  logic [ANCHO_BCD-1:0] bcd, bcd_sig, bcd_ajustado;
  logic [ANCHO_BCD-1:0] salida, salida_sig;
  logic [3:0]           cuenta, cuenta_sig;

  for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_ajuste
    ajuste_suma3 u_ajuste (
      .digito   (bcd[g*ANCHO_DIGITO +: ANCHO_DIGITO]),
      .ajustado (bcd_ajustado[g*ANCHO_DIGITO +: ANCHO_DIGITO])
    );
  end

  always_comb begin
    estado_sig  = estado;
    binario_sig = binario;
    bcd_sig     = bcd;
    cuenta_sig  = cuenta;
    salida_sig  = salida;
    case (estado)
      IDLE: begin
        if (bus.inicio) begin
          binario_sig = bus.dato;
          bcd_sig     = '0;
          cuenta_sig  = '0;
          estado_sig  = CONV;
        end
      end
      CONV: begin
        bcd_sig     = {bcd_ajustado[ANCHO_BCD-2:0], binario[ANCHO-1]};
        binario_sig = binario << 1;
        cuenta_sig  = cuenta + 4'd1;
        // The last iteration's shifted scratch goes straight to the outputs.
        if (cuenta == ULTIMA) begin
          salida_sig = bcd_sig;
          estado_sig = FIN;
        end
      end
      FIN:     estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado  <= IDLE;
      binario <= '0;
      bcd     <= '0;
      cuenta  <= '0;
      salida  <= '0;
    end else begin
      estado  <= estado_sig;
      binario <= binario_sig;
      bcd     <= bcd_sig;
      cuenta  <= cuenta_sig;
      salida  <= salida_sig;
    end
  end

  assign bus.ocupado  = (estado == CONV);
  assign bus.listo    = (estado == FIN);
  assign bus.millares = salida[15:12];
  assign bus.centenas = salida[11:8];
  assign bus.decenas  = salida[7:4];
  assign bus.unidades = salida[3:0];

endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Bench for conversor_binario_bcd: vector table, multi-cycle corner sequences and a full sweep.
module tb_conversor_binario_bcd;

  typedef struct {
    logic [9:0]  dato;
    logic [15:0] bcd;
  } vec_t;

  logic clk;
  logic reset;

  int checks = 0;
  int fails  = 0;

  logic [15:0] q[$];
  logic [15:0] held = '0;
  logic        prev_listo = 1'b0;

  conversor_binario_bcd_if #(.ANCHO(10)) bus ();

  conversor_binario_bcd #(.ANCHO(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nombre, act, exp);
    end
  endtask

  function automatic logic [15:0] modelo(input int unsigned v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] digitos();
    return {bus.millares, bus.centenas, bus.decenas, bus.unidades};
  endfunction

  // Output monitor: pops the scoreboard on every listo, checks held digits every cycle.
  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      q.delete();
      held = '0;
      chk("reset_digitos", 32'(digitos()), 32'h0);
      chk("reset_ocupado", 32'(bus.ocupado), 32'h0);
      chk("reset_listo", 32'(bus.listo), 32'h0);
      prev_listo = 1'b0;
    end else begin
      if (bus.listo) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL listo_unexpected: got listo=1 with no conversion pending, expected 0");
        end else begin
          held = q.pop_front();
        end
      end
      chk("digitos", 32'(digitos()), 32'(held));
      chk("ocupado_y_listo", 32'(bus.ocupado & bus.listo), 32'h0);
      chk("listo_doble", 32'(bus.listo & prev_listo), 32'h0);
      prev_listo = bus.listo;
    end
  end

  task automatic convertir(input logic [9:0] v, input logic [15:0] esperado, input bit ruido);
    int lat;
    @(negedge clk);
    bus.inicio = 1'b1;
    bus.dato   = v;
    q.push_back(esperado);
    @(posedge clk);
    #1;
    chk("ocupado_inicio", 32'(bus.ocupado), 32'h1);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.inicio = ruido && (i == 3 || i == 7);
      if (ruido) bus.dato = 10'($urandom_range(0, 1023));
      @(posedge clk);
      #1;
      if (bus.listo) begin
        lat = i;
        break;
      end
    end
    chk("latencia", 32'(lat), 32'd10);
    @(negedge clk);
    bus.inicio = 1'b0;
  endtask

  vec_t tabla[8];
  int unsigned orden[1024];

  initial begin
    int n;
    tabla[0] = '{dato: 10'd0,    bcd: 16'h0000};
    tabla[1] = '{dato: 10'd1023, bcd: 16'h1023};
    tabla[2] = '{dato: 10'd999,  bcd: 16'h0999};
    tabla[3] = '{dato: 10'd5,    bcd: 16'h0005};
    tabla[4] = '{dato: 10'd9,    bcd: 16'h0009};
    tabla[5] = '{dato: 10'd10,   bcd: 16'h0010};
    tabla[6] = '{dato: 10'd100,  bcd: 16'h0100};
    tabla[7] = '{dato: 10'd1000, bcd: 16'h1000};

    // Reset held low with inicio asserted: the start must be discarded.
    reset      = 1'b0;
    bus.inicio = 1'b1;
    bus.dato   = 10'd77;
    repeat (3) @(negedge clk);
    reset      = 1'b1;
    bus.inicio = 1'b0;
    @(posedge clk);
    #1;
    chk("sin_arranque_tras_reset", 32'(bus.ocupado), 32'h0);

    for (int i = 0; i < 8; i++) convertir(tabla[i].dato, tabla[i].bcd, 1'b0);

    // Start ignored while busy, operand changed under it.
    convertir(10'd512, 16'h0512, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("sin_reinicio", 32'(bus.ocupado), 32'h0);

    // Reset in the middle of a conversion of 1000.
    @(negedge clk);
    bus.inicio = 1'b1;
    bus.dato   = 10'd1000;
    q.push_back(16'h1000);
    @(negedge clk);
    bus.inicio = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_medio_ocupado", 32'(bus.ocupado), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    chk("reset_medio_inactivo", 32'(bus.ocupado), 32'h0);
    convertir(10'd37, 16'h0037, 1'b0);

    // inicio held high: back-to-back conversions every 12 cycles.
    @(negedge clk);
    bus.inicio = 1'b1;
    bus.dato   = 10'd123;
    repeat (3) q.push_back(16'h0123);
    @(posedge clk);
    n = 0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk);
      #1;
      if (bus.listo) begin
        chk("periodo_continuo", 32'(i), 32'(10 + 12 * n));
        n++;
        if (n == 3) break;
      end
    end
    @(negedge clk);
    bus.inicio = 1'b0;
    chk("pulsos_continuos", 32'(n), 32'd3);

    // Every operand value once, in shuffled order.
    for (int unsigned i = 0; i < 1024; i++) orden[i] = i;
    for (int unsigned i = 1023; i > 0; i--) begin
      int unsigned j;
      int unsigned t;
      j        = $urandom_range(0, i);
      t        = orden[i];
      orden[i] = orden[j];
      orden[j] = t;
    end
    for (int unsigned i = 0; i < 1024; i++) convertir(10'(orden[i]), modelo(orden[i]), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("cola_vacia", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
